processor_memory: RTL and testbench
===================================

Name: processor_memory

Overview:
- Responder side of the processor's instruction-fetch and data-memory interfaces.
- Holds a word-addressed instruction RAM and a word-addressed data RAM.
- Serves combinational reads and synchronous writes to the processor's interfaces.
- Includes a byte-stream program loader FSM that fills either RAM while holding the processor off via cpuHold, so programs are loaded at runtime rather than from an initial file.

Parameters:
ADDR_BITS, 8, word-address bits per RAM (depth = 2^ADDR_BITS words of 32 bits)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
instructionAddress  input  32  word address from processor PC
instruction  output  32  instruction word at instructionAddress
memoryAddress  input  32  data word address from processor
memoryOut  input  32  write data from processor (processor's store data)
memoryWE  input  1  processor data write enable
memoryIn  output  32  data word read at memoryAddress
loadStart  input  1  one-cycle pulse: begin a load session
loadTarget  input  1  sampled with loadStart: 0 = instruction RAM, 1 = data RAM
loadByte  input  8  stream byte
loadValid  input  1  loadByte valid
loadLast  input  1  qualifies final byte of session (with loadValid)
loadReady  output  1  loader accepts a byte this cycle
loadDone  output  1  one-cycle pulse: session complete
cpuHold  output  1  high while loading; processor must be held

Behaviour:
- Addressing: only the low ADDR_BITS of instructionAddress/memoryAddress are used; upper bits ignored, so addresses wrap modulo 2^ADDR_BITS.
- Reads: instruction and memoryIn are combinational from the RAM arrays. There is no read latency, because the processor executes a fetched word in the same cycle.
- Processor write: on rising clk with memoryWE=1 and state IDLE, dataRAM[memoryAddress] <= memoryOut. A read of the same address shows the new value from the next cycle.
- memoryWE is ignored while state is LOAD.
- Reset (reset=0, asynchronous):
  - state=IDLE, byteCount=0, loadAddr=0, shift register=0.
  - loadReady=0, loadDone=0, cpuHold=0.
  - RAM contents are NOT cleared.
- FSM states: IDLE, LOAD.
  - IDLE:
    - loadReady=0, cpuHold=0.
    - loadStart=1 -> LOAD; latch loadTarget; loadAddr=0; byteCount=0.
  - LOAD:
    - loadReady=1 and cpuHold=1 every cycle, one byte per cycle maximum.
    - Byte accepted when loadValid & loadReady.
    - Bytes are big-endian: 1st byte -> [31:24], 2nd -> [23:16], 3rd -> [15:8], 4th -> [7:0].
    - On the 4th accepted byte, the assembled word is written at that same edge to target[loadAddr]; loadAddr increments (wraps at 2^ADDR_BITS); byteCount -> 0.
    - Byte accepted with loadLast=1:
      - The word is written immediately; bytes not yet received are zero-filled in the low positions.
      - Next state is IDLE; loadDone=1 for exactly the following cycle.
      - cpuHold falls on the same cycle loadDone rises.
      - If byteCount was 0 before this byte, it still forms a partial word {byte,24'h0}.
    - loadLast without loadValid: ignored.
    - loadStart while in LOAD: ignored.
    - loadValid=0 cycles: stall, state held, no timeout.
- Reset mid-session: the FSM returns to IDLE immediately. Words already written remain; the in-progress partial word is discarded; loadDone is not pulsed.
- loadDone is a registered output, low except the single cycle after the last byte is accepted.

Test Plan:
- Reset then IDLE: processor writes memoryOut=32'hDEADBEEF to memoryAddress=5 with memoryWE=1 -> memoryIn at address 5 reads 32'hDEADBEEF on the next cycle; address 32'h105 reads the same word (wrap, ADDR_BITS=8).
- loadStart with loadTarget=0; stream bytes 8'h12,34,56,78,9A,BC,DE,F0, with loadLast on F0 -> instruction[0]=32'h12345678 and instruction[1]=32'h9ABCDEF0. cpuHold is high from the cycle after loadStart until loadDone; loadDone high exactly 1 cycle.
- Partial word: load to data RAM bytes 8'hAA,8'hBB with loadLast on BB -> dataRAM[0]=32'hAABB0000.
- Stalls and blocking: loadValid toggled 1/0 each cycle during an 8-byte load -> same result as the back-to-back load. memoryWE=1 to address 0 during LOAD has no effect on dataRAM[0].
- Reset mid-session: after 6 bytes of a load, pulse reset low -> cpuHold=0 and loadReady=0 immediately. Word 0 retains the loaded value; word 1 is unchanged; no loadDone pulse.
- Wrap: with ADDR_BITS=2, load 5 words -> the 5th word overwrites word 0, and loadDone pulses once.

Source files
------------

// File: rtl/processor_memory_if.sv
// Processor-side bus of processor_memory: instruction fetch, data access and byte-stream loader.
// The master drives addresses, store data and loader bytes; the slave is the memory block.
interface processor_memory_if;
  logic [31:0] instructionAddress;
  logic [31:0] instruction;
  logic [31:0] memoryAddress;
  logic [31:0] memoryOut;
  logic        memoryWE;
  logic [31:0] memoryIn;
  logic        loadStart;
  logic        loadTarget;
  logic [7:0]  loadByte;
  logic        loadValid;
  logic        loadLast;
  logic        loadReady;
  logic        loadDone;
  logic        cpuHold;

  modport master (
    output instructionAddress, memoryAddress, memoryOut, memoryWE,
    output loadStart, loadTarget, loadByte, loadValid, loadLast,
    input  instruction, memoryIn, loadReady, loadDone, cpuHold
  );

  modport slave (
    input  instructionAddress, memoryAddress, memoryOut, memoryWE,
    input  loadStart, loadTarget, loadByte, loadValid, loadLast,
    output instruction, memoryIn, loadReady, loadDone, cpuHold
  );
endinterface

// File: rtl/processor_memory.sv
// Instruction and data RAMs with combinational reads, plus a big-endian byte-stream loader
// that fills either RAM while holding the processor off.
module processor_memory #(
  parameter int unsigned ADDR_BITS = 8
) (
  input logic               clk,
  input logic               reset,
  processor_memory_if.slave bus_io
);

  localparam int unsigned Depth = 2 ** ADDR_BITS;

  typedef enum logic [0:0] {StIdle, StLoad} state_e;

  state_e                 state_q, state_d;
  logic                   target_q, target_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [1:0]             count_q, count_d;
  logic [31:0]            shift_q, shift_d;
  logic                   done_q, done_d;
  logic                   word_we;
  logic [31:0]            word;

  logic [31:0]            imem [Depth];
  logic [31:0]            dmem [Depth];

  logic [ADDR_BITS-1:0]   i_addr, d_addr;
  logic                   unused_addr_bits;

  assign i_addr = bus_io.instructionAddress[ADDR_BITS-1:0];
  assign d_addr = bus_io.memoryAddress[ADDR_BITS-1:0];
  assign unused_addr_bits = ^{bus_io.instructionAddress[31:ADDR_BITS],
                              bus_io.memoryAddress[31:ADDR_BITS]};

  // Incoming byte lands in its big-endian lane; lower lanes stay zero until filled.
  assign word = shift_q | ({bus_io.loadByte, 24'h0} >> {count_q, 3'b000});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      target_q <= 1'b0;
      addr_q   <= '0;
      count_q  <= 2'd0;
      shift_q  <= 32'h0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      shift_q  <= shift_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    addr_d   = addr_q;
    count_d  = count_q;
    shift_d  = shift_q;
    done_d   = 1'b0;
    word_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus_io.loadStart) begin
          state_d  = StLoad;
          target_d = bus_io.loadTarget;
          addr_d   = '0;
          count_d  = 2'd0;
          shift_d  = 32'h0;
        end
      end
      StLoad: begin
        if (bus_io.loadValid) begin
          if (bus_io.loadLast || count_q == 2'd3) begin
            word_we = 1'b1;
            addr_d  = addr_q + ADDR_BITS'(1);
            count_d = 2'd0;
            shift_d = 32'h0;
          end else begin
            count_d = count_q + 2'd1;
            shift_d = word;
          end
          if (bus_io.loadLast) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus_io.loadReady = (state_q == StLoad);
    bus_io.cpuHold   = (state_q == StLoad);
    bus_io.loadDone  = done_q;
  end

  // RAM contents survive reset, so the arrays live outside the reset domain.
  always_ff @(posedge clk) begin
    if (word_we && !target_q) begin
      imem[addr_q] <= word;
    end
    if (word_we && target_q) begin
      dmem[addr_q] <= word;
    end else if (state_q == StIdle && bus_io.memoryWE) begin
      dmem[d_addr] <= bus_io.memoryOut;
    end
  end

  assign bus_io.instruction = imem[i_addr];
  assign bus_io.memoryIn    = dmem[d_addr];

endmodule

// File: tb/tb_processor_memory.sv
// Bench for processor_memory: two instances (256-word and 4-word) share one stimulus stream
// and are compared every cycle against a queue-based model of loads and processor writes.
module tb_processor_memory;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ia, ma, mo;
  logic        mwe, ls, lt, lv, ll;
  logic [7:0]  lb;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  processor_memory_if if8 ();
  processor_memory_if if2 ();

  assign if8.instructionAddress = ia;
  assign if8.memoryAddress      = ma;
  assign if8.memoryOut          = mo;
  assign if8.memoryWE           = mwe;
  assign if8.loadStart          = ls;
  assign if8.loadTarget         = lt;
  assign if8.loadByte           = lb;
  assign if8.loadValid          = lv;
  assign if8.loadLast           = ll;
  assign if2.instructionAddress = ia;
  assign if2.memoryAddress      = ma;
  assign if2.memoryOut          = mo;
  assign if2.memoryWE           = mwe;
  assign if2.loadStart          = ls;
  assign if2.loadTarget         = lt;
  assign if2.loadByte           = lb;
  assign if2.loadValid          = lv;
  assign if2.loadLast           = ll;

  processor_memory #(.ADDR_BITS(8)) u_dut8 (.clk(clk), .reset(reset), .bus_io(if8.slave));
  processor_memory #(.ADDR_BITS(2)) u_dut2 (.clk(clk), .reset(reset), .bus_io(if2.slave));

  always #5 clk = ~clk;

  // ---------------- model ----------------
  logic [31:0] mi8 [256];
  logic [31:0] md8 [256];
  bit          ki8 [256];
  bit          kd8 [256];
  logic [31:0] mi2 [4];
  logic [31:0] md2 [4];
  bit          ki2 [4];
  bit          kd2 [4];
  bit          loading = 1'b0;
  bit          tgt = 1'b0;
  bit          done_exp = 1'b0;
  int unsigned waddr = 0;
  logic [7:0]  bq [$];

  task automatic mwrite(input bit t, input logic [31:0] a, input logic [31:0] d);
    if (!t) begin
      mi8[a % 256] = d; ki8[a % 256] = 1'b1;
      mi2[a % 4]   = d; ki2[a % 4]   = 1'b1;
    end else begin
      md8[a % 256] = d; kd8[a % 256] = 1'b1;
      md2[a % 4]   = d; kd2[a % 4]   = 1'b1;
    end
  endtask

  task automatic model_step();
    logic [31:0] w;
    if (reset !== 1'b1) return;
    done_exp = 1'b0;
    if (loading) begin
      if (lv) begin
        bq.push_back(lb);
        if (ll || bq.size() == 4) begin
          w = 32'h0;
          for (int i = 0; i < bq.size(); i++) w = w | (32'(bq[i]) << (24 - 8 * i));
          mwrite(tgt, 32'(waddr), w);
          waddr = waddr + 1;
          bq.delete();
        end
        if (ll) begin
          loading  = 1'b0;
          done_exp = 1'b1;
        end
      end
    end else begin
      if (mwe) mwrite(1'b1, ma, mo);
      if (ls) begin
        loading = 1'b1;
        tgt     = lt;
        waddr   = 0;
        bq.delete();
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge reset);
    loading  = 1'b0;
    done_exp = 1'b0;
    bq.delete();
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (if8.loadDone === 1'b1) done_cnt++;
    check("hold8",  32'(if8.cpuHold),   32'(loading));
    check("ready8", 32'(if8.loadReady), 32'(loading));
    check("done8",  32'(if8.loadDone),  32'(done_exp));
    check("hold2",  32'(if2.cpuHold),   32'(loading));
    check("ready2", 32'(if2.loadReady), 32'(loading));
    check("done2",  32'(if2.loadDone),  32'(done_exp));
    if (ki8[ia[7:0]]) check("imem8", if8.instruction, mi8[ia[7:0]]);
    if (kd8[ma[7:0]]) check("dmem8", if8.memoryIn,    md8[ma[7:0]]);
    if (ki2[ia[1:0]]) check("imem2", if2.instruction, mi2[ia[1:0]]);
    if (kd2[ma[1:0]]) check("dmem2", if2.memoryIn,    md2[ma[1:0]]);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_session(input bit t, input logic [7:0] bytes [], input bit stall,
                              input bit we_during, input bit last_on_end);
    ls = 1'b1; lt = t;
    step();
    ls = 1'b0; lt = 1'b0;
    if (we_during) begin
      mwe = 1'b1; ma = 32'h0; mo = 32'hFFFF_FFFF;
    end
    for (int i = 0; i < bytes.size(); i++) begin
      lv = 1'b1; lb = bytes[i]; ll = last_on_end && (i == bytes.size() - 1);
      step();
      if (stall && i != bytes.size() - 1) begin
        lv = 1'b0; ll = 1'b1;
        step();
      end
    end
    lv = 1'b0; ll = 1'b0; mwe = 1'b0;
  endtask

  logic [7:0] b8 [];
  logic [7:0] b2 [];
  logic [7:0] b6 [];
  logic [7:0] b20 [];
  int d0;

  initial begin
    reset = 1'b0;
    ia = 32'h0; ma = 32'h0; mo = 32'h0; mwe = 1'b0;
    ls = 1'b0; lt = 1'b0; lb = 8'h0; lv = 1'b0; ll = 1'b0;
    b8  = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    b2  = '{8'hAA, 8'hBB};
    b6  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    b20 = new[20];
    for (int k = 0; k < 20; k++) b20[k] = 8'(8'h10 + k);

    // Reset state
    step(); step();
    check("rst_hold",  32'(if8.cpuHold),   32'h0);
    check("rst_ready", 32'(if8.loadReady), 32'h0);
    check("rst_done",  32'(if8.loadDone),  32'h0);
    reset = 1'b1;
    step();

    // Processor writes and address wrap
    mwe = 1'b1; ma = 32'd5; mo = 32'hDEAD_BEEF;
    step();
    ma = 32'd1; mo = 32'hCAFE_F00D;
    step();
    mwe = 1'b0; ma = 32'd5;
    #1 check("wr5",    if8.memoryIn, 32'hDEAD_BEEF);
    ma = 32'h105;
    #1 check("wr105",  if8.memoryIn, 32'hDEAD_BEEF);
    ma = 32'd1;
    #1 check("wr1",    if8.memoryIn, 32'hCAFE_F00D);
    step();

    // Back-to-back instruction load
    d0 = done_cnt;
    load_session(1'b0, b8, 1'b0, 1'b0, 1'b1);
    check("b2b_done_now", 32'(if8.loadDone), 32'h1);
    check("b2b_hold_low", 32'(if8.cpuHold),  32'h0);
    step();
    check("b2b_done_once", 32'(done_cnt - d0), 32'h1);
    ia = 32'd0;
    #1 check("b2b_i0", if8.instruction, 32'h1234_5678);
    ia = 32'd1;
    #1 check("b2b_i1", if8.instruction, 32'h9ABC_DEF0);
    step();

    // Partial word into data RAM
    load_session(1'b1, b2, 1'b0, 1'b0, 1'b1);
    step();
    ma = 32'd0;
    #1 check("partial_d0", if8.memoryIn, 32'hAABB_0000);
    step();

    // Stalled load with processor writes attempted during LOAD
    ia = 32'd2;
    mi8[0] = 32'h0; mi8[1] = 32'h0;
    load_session(1'b0, b8, 1'b1, 1'b1, 1'b1);
    step();
    ma = 32'd0; ia = 32'd0;
    #1 check("stall_d0", if8.memoryIn,    32'hAABB_0000);
    check("stall_i0",    if8.instruction, 32'h1234_5678);
    ia = 32'd1;
    #1 check("stall_i1", if8.instruction, 32'h9ABC_DEF0);
    step();

    // Reset mid-session
    d0 = done_cnt;
    load_session(1'b1, b6, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    #1 check("mid_hold",  32'(if8.cpuHold),   32'h0);
    check("mid_ready",    32'(if8.loadReady), 32'h0);
    step(); step();
    reset = 1'b1;
    step(); step();
    check("mid_no_done", 32'(done_cnt - d0), 32'h0);
    ma = 32'd0;
    #1 check("mid_d0", if8.memoryIn, 32'h1122_3344);
    ma = 32'd1;
    #1 check("mid_d1", if8.memoryIn, 32'hCAFE_F00D);
    step();

    // Five-word load: wraps on the 4-word instance
    d0 = done_cnt;
    load_session(1'b0, b20, 1'b0, 1'b0, 1'b1);
    step(); step();
    check("wrap_done_once", 32'(done_cnt - d0), 32'h1);
    ia = 32'd0;
    #1 check("wrap2_i0", if2.instruction, 32'h2021_2223);
    check("wrap8_i0",    if8.instruction, 32'h1011_1213);
    ia = 32'd4;
    #1 check("wrap8_i4", if8.instruction, 32'h2021_2223);
    ia = 32'd3;
    #1 check("wrap2_i3", if2.instruction, 32'h1C1D_1E1F);
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
